// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter (data width, parity, stop bits); optional input FIFO under UART_TX_FIFO_EN.
// Latency: start bit on tx_bit 1 cycle after the transfer edge (2 cycles with the FIFO).
// Backpressure: in_ready low while a frame is in progress (FIFO build: low only while the FIFO is full).

`ifdef UART_TX_FIFO_EN
// Generic synchronous FIFO with first-word fall-through read data.
// Latency: a write is visible on rd_dat and clears empty 1 cycle later.
// Backpressure: writes are dropped while full; reads are ignored while empty.
module uart_tx_cfg_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             user_clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_vld && !full) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_en && !empty) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge user_clk) begin
        if (wr_vld && !full) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end
endmodule
`endif

module uart_tx_cfg #(
    parameter int CLK_FREQUENCY  = 66_000_000,
    parameter int UART_FREQUENCY = 921_600,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                 user_clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 tx_bit,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int TICKS_PER_BIT = CLK_FREQUENCY / UART_FREQUENCY;
    localparam int TW = $clog2(TICKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
`ifdef UART_TX_FIFO_EN
    localparam bit FIFO_ON = 1'b1;
`else
    localparam bit FIFO_ON = 1'b0;
`endif

    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (TICKS_PER_BIT < 2) begin : g_bad_ticks
        $error("uart_tx_cfg: CLK_FREQUENCY / UART_FREQUENCY must be >= 2");
    end
    if (FIFO_ON && (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  done_d;
    logic                  bit_end;
    logic                  cap_vld;
    logic [DATA_BITS-1:0]  cap_dat;

`ifdef UART_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    uart_tx_cfg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .user_clk (user_clk),
        .rst_n    (rst_n),
        .wr_vld   (in_valid),
        .wr_dat   (in_data),
        .rd_en    (cap_vld),
        .rd_dat   (cap_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Pop into the shifter only while idle; the start bit follows on the next cycle.
    assign cap_vld  = (state_q == S_IDLE) && !fifo_empty;
    assign in_ready = !fifo_full;
    assign busy     = (state_q != S_IDLE) || !fifo_empty;
`else
    assign cap_vld  = in_valid && (state_q == S_IDLE);
    assign cap_dat  = in_data;
    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
`endif

    assign tx_bit     = tx_q;
    assign frame_done = done_d;
    assign bit_end    = (tick_q == TICK_LAST);

    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) tick_d = bit_end ? '0 : tick_q + TICK_ONE;

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (cap_vld) begin
                    state_d = S_START;
                    shift_d = cap_dat;
                    par_d   = (PARITY == 1) ? ~(^cap_dat) : ^cap_dat;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                // bit_q counts stop bits here
                if (bit_end) begin
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations (8N1, 8E1, 8O1, 5N2) at 8 clocks per bit,
// expected frames queued at each accepted transfer and compared cycle by cycle on tx_bit.
module tb_uart_tx_cfg;
    localparam int T = 8;
`ifdef UART_TX_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif
    localparam int LAT = FIFO ? 2 : 1;

    typedef struct {
        logic [8:0] d;
        int         acc;
        int         gap;
    } exp_t;

    logic       user_clk;
    logic       rst_n;
    logic       tb_vld;
    logic [8:0] tb_dat;
    logic [3:0] vld_w, rdy_w, tx_w, busy_w, done_w;
    int         sel;
    int         cyc;
    int         exp_gap_next;
    int         n_checks;
    int         n_errors;

    exp_t        sb[$];
    exp_t        cur;
    logic [15:0] fb;
    int          nlen;
    bit          infr;
    bit          post;
    int          mon_k;
    int          last_end;

    logic tx_s, busy_s, done_s, rdy_s;
    assign vld_w  = tb_vld ? (4'b0001 << sel) : 4'b0000;
    assign tx_s   = tx_w[sel];
    assign busy_s = busy_w[sel];
    assign done_s = done_w[sel];
    assign rdy_s  = rdy_w[sel];

    uart_tx_cfg #(.CLK_FREQUENCY(8), .UART_FREQUENCY(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .user_clk(user_clk), .rst_n(rst_n), .in_valid(vld_w[0]), .in_data(tb_dat[7:0]),
        .in_ready(rdy_w[0]), .tx_bit(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));
    uart_tx_cfg #(.CLK_FREQUENCY(8), .UART_FREQUENCY(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .user_clk(user_clk), .rst_n(rst_n), .in_valid(vld_w[1]), .in_data(tb_dat[7:0]),
        .in_ready(rdy_w[1]), .tx_bit(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));
    uart_tx_cfg #(.CLK_FREQUENCY(8), .UART_FREQUENCY(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .user_clk(user_clk), .rst_n(rst_n), .in_valid(vld_w[2]), .in_data(tb_dat[7:0]),
        .in_ready(rdy_w[2]), .tx_bit(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));
    uart_tx_cfg #(.CLK_FREQUENCY(8), .UART_FREQUENCY(1), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_5n2 (
        .user_clk(user_clk), .rst_n(rst_n), .in_valid(vld_w[3]), .in_data(tb_dat[4:0]),
        .in_ready(rdy_w[3]), .tx_bit(tx_w[3]), .busy(busy_w[3]), .frame_done(done_w[3]));

    initial begin
        user_clk = 1'b0;
        forever #5 user_clk = ~user_clk;
    end

    initial cyc = 0;
    always @(posedge user_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, sel %0d)", tag, got, exp, cyc, sel);
        end
    endtask

    function automatic int cfg_bits(input int s);
        return (s == 3) ? 5 : 8;
    endfunction
    function automatic int cfg_par(input int s);
        return (s == 1) ? 2 : (s == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_stop(input int s);
        return (s == 3) ? 2 : 1;
    endfunction

    function automatic int pending();
        foreach (sb[i]) if (sb[i].acc <= cyc) return 1;
        return 0;
    endfunction

    // Expected line levels for one frame, one entry per bit period.
    task automatic build_frame(input logic [8:0] d);
        int         nb, idx;
        logic [8:0] dm;
        nb  = cfg_bits(sel);
        dm  = d & 9'((1 << nb) - 1);
        fb  = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < nb; i++) fb[1 + i] = dm[i];
        idx = 1 + nb;
        if (cfg_par(sel) == 2) begin fb[idx] = ^dm; idx++; end
        if (cfg_par(sel) == 1) begin fb[idx] = ~(^dm); idx++; end
        nlen = idx + cfg_stop(sel);
    endtask

    always @(negedge user_clk) begin
        if (!rst_n) begin
            infr  = 0;
            post  = 0;
            mon_k = 0;
        end else begin
            if (post) begin
                post = 0;
                check("idle_tx", tx_s, 1);
                check("idle_busy", busy_s, FIFO ? pending() : 0);
                if (!FIFO) check("idle_ready", rdy_s, 1);
            end
            if (!infr) begin
                check("idle_frame_done", done_s, 0);
                if (tx_s == 1'b0) begin
                    if (sb.size() == 0) begin
                        check("spurious_start", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        build_frame(cur.d);
                        if (!FIFO || cur.gap == 0) check("start_latency", cyc - cur.acc, LAT - 1);
                        if (cur.gap != 0) check("frame_gap", cyc - last_end, cur.gap);
                        infr  = 1;
                        mon_k = 0;
                    end
                end
            end
            if (infr) begin
                mon_k++;
                check("tx_bit", tx_s, fb[(mon_k - 1) / T]);
                check("busy", busy_s, 1);
                check("frame_done", done_s, (mon_k == nlen * T) ? 1 : 0);
                if (!FIFO) check("ready_in_frame", rdy_s, 0);
                if (mon_k == nlen * T) begin
                    infr     = 0;
                    post     = 1;
                    last_end = cyc;
                    mon_k    = 0;
                end
            end
            if (tb_vld && rdy_s) sb.push_back('{d: tb_dat, acc: cyc + 1, gap: exp_gap_next});
        end
    end

    // Called just after a rising edge; returns just after the rising edge that took the transfer.
    task automatic send(input logic [8:0] d, input int gap);
        int n;
        n = 0;
        tb_dat       = d;
        exp_gap_next = gap;
        tb_vld       = 1'b1;
        @(negedge user_clk);
        while (!rdy_s && n < 2000) begin
            @(negedge user_clk);
            n++;
        end
        if (n >= 2000) check("send_timeout", 1, 0);
        @(posedge user_clk);
        #1;
        tb_vld = 1'b0;
        tb_dat = 9'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || infr || post) && n < 3000) begin
            @(posedge user_clk);
            n++;
        end
        if (n >= 3000) check("idle_timeout", 1, 0);
        @(posedge user_clk);
        #1;
    endtask

    initial begin
        int n;
        n_checks     = 0;
        n_errors     = 0;
        sel          = 0;
        tb_vld       = 1'b0;
        tb_dat       = '0;
        exp_gap_next = 0;
        infr         = 0;
        post         = 0;
        mon_k        = 0;
        last_end     = 0;
        rst_n        = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx", tx_w, 4'hF);
        check("rst_busy", busy_w, 0);
        check("rst_frame_done", done_w, 0);
        check("rst_ready", rdy_w, 4'hF);
        repeat (3) @(posedge user_clk);
        #3 rst_n = 1'b1;
        @(posedge user_clk);
        #1;

        sel = 0; send(9'h0A5, 0); wait_idle();
        sel = 1; send(9'h007, 0); wait_idle();
        sel = 2; send(9'h007, 0); wait_idle();
        sel = 3; send(9'h01F, 0); wait_idle();
        sel = 3; send(9'h00A, 0); wait_idle();

        // in_valid held across both transfers
        sel = 0;
        send(9'h055, 0);
        send(9'h0AA, 2);
        wait_idle();

        // asynchronous reset in the middle of a frame
        sel = 0;
        send(9'h0C3, 0);
        n = 0;
        while (mon_k < 30 && n < 500) begin
            @(posedge user_clk);
            n++;
        end
        if (n >= 500) check("mid_frame_timeout", 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_tx", tx_s, 1);
        check("abort_busy", busy_s, 0);
        check("abort_frame_done", done_s, 0);
        check("abort_ready", rdy_s, 1);
        repeat (2) @(posedge user_clk);
        #3 rst_n = 1'b1;
        check("abort_queue", sb.size(), 0);
        @(posedge user_clk);
        #1;
        send(9'h03C, 0);
        wait_idle();

        if (FIFO) begin
            // one pop happens after the first push, so five pushes fill four entries
            sel    = 0;
            tb_vld = 1'b1;
            for (int i = 0; i < 6; i++) begin
                tb_dat       = 9'(8'h11 * (i + 1));
                exp_gap_next = (i == 0) ? 0 : 2;
                @(negedge user_clk);
                check("fifo_ready", rdy_s, (i < 5) ? 1 : 0);
                @(posedge user_clk);
                #1;
            end
            tb_vld = 1'b0;
            wait_idle();
        end

        for (int s = 0; s < 4; s++) begin
            sel = s;
            for (int j = 0; j < 2; j++) begin
                send(9'($urandom), 0);
                wait_idle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
